// File: rtl/orb_status_pkg.sv
// Shared constants and helpers for the orbtrace status/indicator engine.
// The ORB_STATUS_FAST_TICK_EN build uses FAST_TICK_DIV as the millisecond divider.
package orb_status_pkg;

  localparam int TICK_HZ       = 1000;
  localparam int FAST_TICK_DIV = 4;
  localparam int OVF_CNT_W     = 8;
  localparam int STRETCH_W     = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/orb_act_stretch.sv
// One activity channel: a load/decrement millisecond counter that keeps the
// LED lit for at least STRETCH_MS after the last active cycle.
module orb_act_stretch
  import orb_status_pkg::*;
#(
  parameter int STRETCH_MS = 20
) (
  input  logic clkOut,
  input  logic rst,
  input  logic act_i,
  input  logic tick_i,
  output logic led_o
);

  localparam logic [STRETCH_W-1:0] LOAD = STRETCH_W'(STRETCH_MS);

  logic [STRETCH_W-1:0] cnt_q, cnt_d;
  logic                 led_q, led_d;

  // A fresh event always reloads the full time, so a retrigger never dims the LED.
  always_comb begin
    cnt_d = cnt_q;
    if (act_i) begin
      cnt_d = LOAD;
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
    led_d = (cnt_d != '0);
  end

  always_ff @(posedge clkOut) begin
    if (rst) begin
      cnt_q <= '0;
      led_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      led_q <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/orb_status.sv
// Status LED engine: millisecond prescaler, stretched activity LEDs, sync-rate
// heartbeat and sticky overflow count. ORB_STATUS_FAST_TICK_EN forces a 4-cycle tick.
module orb_status
  import orb_status_pkg::*;
#(
  parameter int CLOCKFRQ     = 48_000_000,
  parameter int NUM_CH       = 4,
  parameter int STRETCH_MS   = 20,
  parameter int HEARTBEAT_MS = 1000
) (
  input  logic                 clkOut,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    act,
  input  logic                 sync,
  input  logic                 ovf,
  input  logic                 ovf_clr,
  output logic [NUM_CH-1:0]    led_act,
  output logic                 led_heartbeat,
  output logic                 led_sync,
  output logic                 led_ovf,
  output logic [OVF_CNT_W-1:0] ovf_count
);

`ifdef ORB_STATUS_FAST_TICK_EN
  localparam int TICK_DIV = FAST_TICK_DIV;
`else
  localparam int TICK_DIV = CLOCKFRQ / TICK_HZ;
`endif
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam int HB_W = $clog2(HEARTBEAT_MS / 2 + 1);
  localparam logic [HB_W-1:0] HB_LAST_SYNC   = HB_W'(HEARTBEAT_MS / 2 - 1);
  localparam logic [HB_W-1:0] HB_LAST_NOSYNC = HB_W'(HEARTBEAT_MS / 8 - 1);

  logic [PRE_W-1:0]     pre_q, pre_d;
  logic                 tick;
  logic [HB_W-1:0]      hb_q, hb_d;
  logic                 hb_led_q, hb_led_d;
  logic                 sync_q;
  logic                 ovf_led_q, ovf_led_d;
  logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [HB_W-1:0]      hb_last;

  assign tick    = (pre_q == PRE_LAST);
  assign hb_last = sync ? HB_LAST_SYNC : HB_LAST_NOSYNC;

  always_comb begin
    pre_d     = tick ? '0 : pre_q + 1'b1;
    hb_d      = hb_q;
    hb_led_d  = hb_led_q;
    ovf_led_d = ovf_led_q;
    ovf_cnt_d = ovf_cnt_q;

    // >= rather than == so a shrinking limit toggles on the next tick instead of wrapping.
    if (tick) begin
      if (hb_q >= hb_last) begin
        hb_d     = '0;
        hb_led_d = ~hb_led_q;
      end else begin
        hb_d = hb_q + 1'b1;
      end
    end

    // A coincident clear and event restarts the count at one so the event survives.
    if (ovf) begin
      ovf_led_d = 1'b1;
      ovf_cnt_d = ovf_clr ? OVF_CNT_W'(1) : sat_inc(ovf_cnt_q);
    end else if (ovf_clr) begin
      ovf_led_d = 1'b0;
      ovf_cnt_d = '0;
    end
  end

  always_ff @(posedge clkOut) begin
    if (rst) begin
      pre_q     <= '0;
      hb_q      <= '0;
      hb_led_q  <= 1'b0;
      sync_q    <= 1'b0;
      ovf_led_q <= 1'b0;
      ovf_cnt_q <= '0;
    end else begin
      pre_q     <= pre_d;
      hb_q      <= hb_d;
      hb_led_q  <= hb_led_d;
      sync_q    <= sync;
      ovf_led_q <= ovf_led_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    orb_act_stretch #(
      .STRETCH_MS(STRETCH_MS)
    ) u_stretch (
      .clkOut(clkOut),
      .rst   (rst),
      .act_i (act[gi]),
      .tick_i(tick),
      .led_o (led_act[gi])
    );
  end

  assign led_heartbeat = hb_led_q;
  assign led_sync      = sync_q;
  assign led_ovf       = ovf_led_q;
  assign ovf_count     = ovf_cnt_q;

endmodule

// File: tb/tb_orb_status.sv
// Directed bench for orb_status; CLOCKFRQ=4000 gives a 4-cycle millisecond tick
// in either build, with STRETCH_MS=5, HEARTBEAT_MS=16, NUM_CH=4.
module tb_orb_status;

  logic       clkOut = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] act = 4'h0;
  logic       sync = 1'b0;
  logic       ovf = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [3:0] led_act;
  logic       led_heartbeat, led_sync, led_ovf;
  logic [7:0] ovf_count;

  int total = 0;
  int bad   = 0;
  int n;
  int low_seen;

  always #5 clkOut = ~clkOut;

  orb_status #(
    .CLOCKFRQ    (4000),
    .NUM_CH      (4),
    .STRETCH_MS  (5),
    .HEARTBEAT_MS(16)
  ) dut (
    .clkOut       (clkOut),
    .rst          (rst),
    .act          (act),
    .sync         (sync),
    .ovf          (ovf),
    .ovf_clr      (ovf_clr),
    .led_act      (led_act),
    .led_heartbeat(led_heartbeat),
    .led_sync     (led_sync),
    .led_ovf      (led_ovf),
    .ovf_count    (ovf_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int cycles);
    repeat (cycles) @(posedge clkOut);
    #1;
  endtask

  // Edges until led_act[ch] goes low; -1 if it never does.
  task automatic fall_len(input int ch, output int len);
    len = 0;
    for (int k = 0; k < 60; k++) begin
      step(1);
      len++;
      if (!led_act[ch]) return;
    end
    len = -1;
  endtask

  // Edges until led_heartbeat changes; -1 if it never does.
  task automatic wait_toggle(output int len);
    logic prev;
    prev = led_heartbeat;
    len = 0;
    for (int k = 0; k < 100; k++) begin
      step(1);
      len++;
      if (led_heartbeat !== prev) return;
    end
    len = -1;
  endtask

  initial begin
    // Reset with every input active: outputs must stay 0.
    rst = 1'b1; act = 4'hF; ovf = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("reset_outputs", {led_act, led_heartbeat, led_sync, led_ovf, ovf_count}, 0);
    end
    rst = 1'b0; act = 4'h0; ovf = 1'b0;
    step(1);  // E1; prescaler ticks on E4, E8, ...
    chk("reset_ovf_count", ovf_count, 0);
    chk("reset_release_outputs", {led_act, led_heartbeat, led_ovf, ovf_count}, 0);

    // Single stretch: act sampled at E2, five ticks E4..E20 -> low after 18 edges.
    act = 4'b0100;
    step(1);
    act = 4'h0;
    chk("stretch_rise", led_act, 4'b0100);
    fall_len(2, n);
    chk("stretch_len", n, 18);
    chk("stretch_after", led_act, 0);

    // Retrigger: act[0] at E21 and E33; last load at E33 runs out at E52.
    act = 4'b0001;
    step(1);
    act = 4'h0;
    low_seen = 0;
    for (int i = 0; i < 11; i++) begin
      step(1);
      if (!led_act[0]) low_seen++;
    end
    chk("retrig_continuous", low_seen, 0);
    act = 4'b0001;
    step(1);
    act = 4'h0;
    chk("retrig_lit", led_act[0], 1);
    fall_len(0, n);
    chk("retrig_len", n, 19);

    // Reset five cycles into a fresh stretch on channel 3.
    act = 4'b1000;
    step(1);
    act = 4'h0;
    chk("rst_mid_lit", led_act[3], 1);
    step(4);
    rst = 1'b1;
    step(1);
    chk("rst_mid_outputs", {led_act, led_heartbeat, led_sync, led_ovf, ovf_count}, 0);

    // Heartbeat in sync: L=8 ticks -> 32 cycles per half-period.
    rst = 1'b0; sync = 1'b1;
    wait_toggle(n);
    chk("hb_sync_first", n, 32);
    chk("led_sync_high", led_sync, 1);
    wait_toggle(n);
    chk("hb_sync_second", n, 32);
    step(24);  // hb = 6, on a tick edge
    sync = 1'b0;
    wait_toggle(n);
    chk("hb_drop_next_tick", n, 4);
    chk("led_sync_low", led_sync, 0);
    wait_toggle(n);
    chk("hb_nosync_period", n, 8);
    sync = 1'b1;
    wait_toggle(n);
    chk("hb_resync_period", n, 32);

    // Overflow saturation.
    for (int i = 0; i < 300; i++) begin
      ovf = 1'b1;
      step(1);
      ovf = 1'b0;
      if (i == 0) begin
        chk("ovf_first_count", ovf_count, 1);
        chk("ovf_first_led", led_ovf, 1);
      end
      step(1);
    end
    chk("ovf_sat_count", ovf_count, 255);
    chk("ovf_sat_led", led_ovf, 1);

    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("ovf_clr_count", ovf_count, 0);
    chk("ovf_clr_led", led_ovf, 0);

    // A 3-cycle ovf level counts three events.
    ovf = 1'b1;
    step(3);
    ovf = 1'b0;
    chk("ovf_long_count", ovf_count, 3);

    ovf = 1'b1; ovf_clr = 1'b1;
    step(1);
    ovf = 1'b0; ovf_clr = 1'b0;
    chk("ovf_both_count", ovf_count, 1);
    chk("ovf_both_led", led_ovf, 1);
    step(1);
    chk("ovf_hold_count", ovf_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/orb_status.md
# orb_status

Parametrised status/indicator engine for the orbtrace top level, replacing the ad-hoc heartbeat counter and raw LED wiring. It takes per-channel activity strobes, the trace sync flag and the FIFO overflow strobe, all in the clkOut domain. It drives stretched, human-visible LEDs, a sync-dependent heartbeat and a sticky overflow indicator with a saturating event count. It sits beside packSend/uart and drives the board LED pins directly.

## Interface
- CLOCKFRQ, 48_000_000: clkOut frequency in Hz; sets the millisecond tick divider.
- NUM_CH, 4: number of activity channels, 1..8.
- STRETCH_MS, 20: minimum LED on-time per activity event in ms, 1..65535.
- HEARTBEAT_MS, 1000: heartbeat period in sync, in ms; even, ≥ 8.
- clkOut  input  1  system clock.
- rst  input  1  reset: synchronous, active-high, sampled on clkOut.
- act  input  NUM_CH  activity level/strobe per channel; any cycle high counts as an event.
- sync  input  1  trace decoder in sync.
- ovf  input  1  overflow event strobe.
- ovf_clr  input  1  clear the overflow latch and count.
- led_act  output  NUM_CH  stretched activity LEDs.
- led_heartbeat  output  1  heartbeat LED.
- led_sync  output  1  registered copy of sync.
- led_ovf  output  1  sticky overflow LED.
- ovf_count  output  8  saturating overflow event count.

## Operation
- All outputs are registered and reset to 0.
- Reset clears every counter, including the prescaler phase.

**Prescaler**
- Counts 0..TICK_DIV-1, with TICK_DIV = CLOCKFRQ/1000.
- Produces a single-cycle `tick` on the cycle the count equals TICK_DIV-1, then wraps to 0.
- Counter width is $clog2(TICK_DIV).

**Activity stretcher (per channel)**
- 16-bit counter `cnt`.
- If act[i]=1, load STRETCH_MS. Load wins over decrement on the same cycle.
- Else, if tick=1 and cnt≠0, decrement.
- led_act[i]_next = (cnt_next ≠ 0).
- Retrigger while lit reloads to the full STRETCH_MS. The LED does not blink off between events.

**Heartbeat**
- Tick counter `hb` with limit L:
  - L = HEARTBEAT_MS/2 when sync=1.
  - L = HEARTBEAT_MS/8 when sync=0 (fast blink = not in sync).
- On tick: if hb ≥ L-1, set hb←0 and toggle led_heartbeat; else increment hb.
- The ≥ compare guarantees that when sync drops mid-period with hb already above the new limit, the toggle happens on the very next tick. No long stall.

**Sync LED**
- led_sync = sync delayed by one register.

**Overflow**
- ovf=1 sets led_ovf and increments ovf_count, saturating at 255.
- ovf_clr=1 with ovf=0: led_ovf←0, ovf_count←0.
- ovf_clr=1 with ovf=1 on the same cycle: led_ovf←1, ovf_count←1. The new event is never lost.

## Timing
- act→led_act rising latency: 1 clkOut cycle.
- Stretch duration after the last act-high cycle: (STRETCH_MS-1)·TICK_DIV+1 to STRETCH_MS·TICK_DIV cycles, depending on prescaler phase.
- Heartbeat half-period: exactly L·TICK_DIV cycles in steady state.
- ovf→led_ovf/ovf_count latency: 1 cycle.
- sync→led_sync latency: 1 cycle.
- rst asserted mid-operation: all outputs are 0 on the following edge. The prescaler restarts at 0 after release.
- No input handshake is used: strobes of any length are accepted every cycle. ovf pulses longer than one cycle count once per cycle.

## Configuration
- Macro: `ORB_STATUS_FAST_TICK_EN`.
- Defined: TICK_DIV is forced to 4, independent of CLOCKFRQ, so that simulation benches observe ms-scale behaviour in tens of cycles.
- Undefined: TICK_DIV = CLOCKFRQ/1000 (48000 at default).
- No other behaviour differs between the two builds.

## Structure
- Package `orb_status_pkg` holds:
  - TICK_HZ = 1000;
  - FAST_TICK_DIV = 4;
  - OVF_CNT_W = 8;
  - STRETCH_W = 16.
- Sub-module `orb_act_stretch` is the one-channel load/decrement counter with registered LED output. It is instantiated NUM_CH times in a generate loop.
- Prescaler, heartbeat and overflow logic live in `orb_status`.

## Test plan
All scenarios are built with `ORB_STATUS_FAST_TICK_EN` defined, so TICK_DIV=4; settings are STRETCH_MS=5, HEARTBEAT_MS=16, NUM_CH=4.

- **Reset:** rst held 3 cycles with act=4'hF, ovf=1 -> every output 0 throughout, and ovf_count=0 on the cycle after release.
- **Single stretch:** one-cycle act[2] pulse -> led_act[2]=1 next cycle, stays high 17..20 cycles; led_act[0,1,3] remain 0.
- **Retrigger and reset:**
  - act[0] pulsed at t=0 and t=12 -> led_act[0] continuously high until 17..20 cycles after t=12.
  - rst at t=5 of a new stretch -> led_act 0 next cycle.
- **Heartbeat:**
  - sync=1 -> led_heartbeat toggles every 32 cycles.
  - sync dropped with hb=6 -> toggle at next tick, then every 8 cycles.
  - sync restored -> 32-cycle half-period resumes.
- **Overflow:**
  - 300 single-cycle ovf pulses -> ovf_count=255, led_ovf=1.
  - ovf_clr alone -> 0/0.
  - ovf_clr and ovf together -> ovf_count=1, led_ovf=1.
